// File: rtl/ram_port_arbiter_if.sv
// Request/response bundle for one requester of ram_port_arbiter.
// The arbiter takes the slave side and the requester takes the master side.
interface ram_port_arbiter_if #(
   parameter int DBITS = 8,
   parameter int ABITS = 12
);
   logic             req_valid;
   logic             req_ready;
   logic             req_we;
   logic [ABITS-1:0] req_addr;
   logic [DBITS-1:0] req_wdata;
   logic             resp_valid;
   logic [DBITS-1:0] resp_rdata;

   modport master (
      output req_valid,
      output req_we,
      output req_addr,
      output req_wdata,
      input  req_ready,
      input  resp_valid,
      input  resp_rdata
   );

   modport slave (
      input  req_valid,
      input  req_we,
      input  req_addr,
      input  req_wdata,
      output req_ready,
      output resp_valid,
      output resp_rdata
   );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing RAM port 0 between requesters m0 and m1.
// Define RAM_ARB_ZERO_INIT_EN to zero-fill the whole RAM after reset.
module ram_port_arbiter #(
   parameter int DBITS = 8,
   parameter int ABITS = 12
) (
   input  logic              clk,
   input  logic              rst,
   ram_port_arbiter_if.slave m0,
   ram_port_arbiter_if.slave m1,
   output logic [ABITS-1:0]  ram_addr0,
   output logic              ram_re0,
   output logic              ram_we0,
   output logic [DBITS-1:0]  ram_wr0,
   input  logic [DBITS-1:0]  ram_rd0,
   output logic              init_done
);

   logic run_w;
   logic g0_w;
   logic g1_w;
   // 1 = m1 was granted last, so m0 wins the next tie
   logic rr_last_q, rr_last_d;
   logic rv0_q, rv0_d;
   logic rv1_q, rv1_d;
   logic init_done_q, init_done_d;

`ifdef RAM_ARB_ZERO_INIT_EN
   typedef enum logic {
      ST_INIT,
      ST_RUN
   } state_e;

   localparam logic [ABITS-1:0] LAST = '1;

   state_e           state_q, state_d;
   logic [ABITS-1:0] cnt_q, cnt_d;
   logic             ini_w;

   assign run_w = (state_q == ST_RUN) & ~rst;
   assign ini_w = (state_q == ST_INIT) & ~rst;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      init_done_d = init_done_q;
      if (state_q == ST_INIT) begin
         if (cnt_q == LAST) begin
            state_d     = ST_RUN;
            init_done_d = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end
`else
   assign run_w       = ~rst;
   assign init_done_d = 1'b1;
`endif

   assign g0_w = run_w & m0.req_valid
               & (~m1.req_valid | rr_last_q);
   assign g1_w = run_w & m1.req_valid
               & (~m0.req_valid | ~rr_last_q);

   always_comb begin
      rr_last_d = rr_last_q;
      if (g1_w) begin
         rr_last_d = 1'b1;
      end else if (g0_w) begin
         rr_last_d = 1'b0;
      end
   end

   assign rv0_d = g0_w & ~m0.req_we;
   assign rv1_d = g1_w & ~m1.req_we;

   always_comb begin
      ram_addr0 = '0;
      ram_re0   = 1'b0;
      ram_we0   = 1'b0;
      ram_wr0   = '0;
      if (g0_w) begin
         ram_addr0 = m0.req_addr;
         ram_re0   = ~m0.req_we;
         ram_we0   = m0.req_we;
         ram_wr0   = m0.req_wdata;
      end else if (g1_w) begin
         ram_addr0 = m1.req_addr;
         ram_re0   = ~m1.req_we;
         ram_we0   = m1.req_we;
         ram_wr0   = m1.req_wdata;
      end
`ifdef RAM_ARB_ZERO_INIT_EN
      if (ini_w) begin
         ram_addr0 = cnt_q;
         ram_we0   = 1'b1;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_last_q   <= 1'b1;
         rv0_q       <= 1'b0;
         rv1_q       <= 1'b0;
         init_done_q <= 1'b0;
`ifdef RAM_ARB_ZERO_INIT_EN
         state_q     <= ST_INIT;
         cnt_q       <= '0;
`endif
      end else begin
         rr_last_q   <= rr_last_d;
         rv0_q       <= rv0_d;
         rv1_q       <= rv1_d;
         init_done_q <= init_done_d;
`ifdef RAM_ARB_ZERO_INIT_EN
         state_q     <= state_d;
         cnt_q       <= cnt_d;
`endif
      end
   end

   assign m0.req_ready  = g0_w;
   assign m1.req_ready  = g1_w;
   // a response in flight when reset arrives is suppressed
   assign m0.resp_valid = rv0_q & ~rst;
   assign m1.resp_valid = rv1_q & ~rst;
   assign m0.resp_rdata = ram_rd0;
   assign m1.resp_rdata = ram_rd0;
   assign init_done     = init_done_q & ~rst;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter with a registered-read RAM model.
// Directed vectors push expected read data; a monitor checks responses.
module tb_ram_port_arbiter;
   localparam int DBITS = 8;
   localparam int ABITS = 12;
   localparam int DEPTH = 1 << ABITS;

   logic             clk = 1'b0;
   logic             rst;
   logic [ABITS-1:0] ram_addr0;
   logic             ram_re0;
   logic             ram_we0;
   logic [DBITS-1:0] ram_wr0;
   logic [DBITS-1:0] ram_rd0 = '0;
   logic             init_done;
   logic [DBITS-1:0] mem [DEPTH];

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;

   typedef struct {
      int               c;
      logic [DBITS-1:0] d;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];

   ram_port_arbiter_if #(.DBITS(DBITS), .ABITS(ABITS)) m0_if ();
   ram_port_arbiter_if #(.DBITS(DBITS), .ABITS(ABITS)) m1_if ();

   ram_port_arbiter #(.DBITS(DBITS), .ABITS(ABITS)) dut (
      .clk       (clk),
      .rst       (rst),
      .m0        (m0_if.slave),
      .m1        (m1_if.slave),
      .ram_addr0 (ram_addr0),
      .ram_re0   (ram_re0),
      .ram_we0   (ram_we0),
      .ram_wr0   (ram_wr0),
      .ram_rd0   (ram_rd0),
      .init_done (init_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (ram_we0) mem[ram_addr0] <= ram_wr0;
      if (ram_re0) ram_rd0 <= mem[ram_addr0];
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   task automatic mon(input string nm, input logic v,
                      input logic [DBITS-1:0] d, ref exp_t q[$]);
      exp_t e;
      if (v) begin
         if (q.size() == 0) begin
            chk({nm, " unexpected resp"}, 32'd1, 32'd0);
         end else begin
            e = q.pop_front();
            chk({nm, " resp cycle"}, cyc, e.c + 1);
            chk({nm, " resp data"}, d, e.d);
         end
      end else if (q.size() != 0 && q[0].c + 1 < cyc) begin
         e = q.pop_front();
         chk({nm, " missing resp"}, 32'd0, 32'd1);
      end
   endtask

   always @(negedge clk) begin
      mon("m0", m0_if.resp_valid, m0_if.resp_rdata, q0);
      mon("m1", m1_if.resp_valid, m1_if.resp_rdata, q1);
      if (ram_re0 === 1'b1)
         chk("re0/we0 exclusive", ram_we0, 1'b0);
   end

   task automatic step(
      input logic v0, input logic w0,
      input logic [ABITS-1:0] a0, input logic [DBITS-1:0] d0,
      input logic v1, input logic w1,
      input logic [ABITS-1:0] a1, input logic [DBITS-1:0] d1,
      input logic [1:0] eg, input logic [DBITS-1:0] erd,
      input bit push = 1'b1);
      exp_t e;
      m0_if.req_valid = v0;
      m0_if.req_we    = w0;
      m0_if.req_addr  = a0;
      m0_if.req_wdata = d0;
      m1_if.req_valid = v1;
      m1_if.req_we    = w1;
      m1_if.req_addr  = a1;
      m1_if.req_wdata = d1;
      @(negedge clk);
      chk("grant", {m1_if.req_ready, m0_if.req_ready}, eg);
      chk("ram_re0", ram_re0, (eg[0] & ~w0) | (eg[1] & ~w1));
      chk("ram_we0", ram_we0, (eg[0] & w0) | (eg[1] & w1));
      if (eg != 2'b00) chk("ram_addr0", ram_addr0, eg[0] ? a0 : a1);
      e.c = cyc;
      e.d = erd;
      if (push && eg[0] && !w0) q0.push_back(e);
      if (push && eg[1] && !w1) q1.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      step(0, 0, '0, '0, 0, 0, '0, '0, 2'b00, '0);
   endtask

   task automatic wait_init();
`ifdef RAM_ARB_ZERO_INIT_EN
      for (int i = 0; i < DEPTH; i++) begin
         @(negedge clk);
         chk("zero-fill", {ram_we0, ram_re0, ram_addr0, ram_wr0},
             {1'b1, 1'b0, ABITS'(i), {DBITS{1'b0}}});
         chk("init_done low", init_done, 1'b0);
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      chk("init_done high", init_done, 1'b1);
      @(posedge clk);
      #1;
`else
      @(negedge clk);
      chk("init_done first", init_done, 1'b0);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("init_done high", init_done, 1'b1);
      @(posedge clk);
      #1;
`endif
   endtask

   initial begin
      rst = 1'b1;
      m0_if.req_valid = 1'b1;
      m0_if.req_we    = 1'b0;
      m0_if.req_addr  = 12'h001;
      m0_if.req_wdata = '0;
      m1_if.req_valid = 1'b1;
      m1_if.req_we    = 1'b1;
      m1_if.req_addr  = 12'h002;
      m1_if.req_wdata = 8'hFF;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst ready", {m1_if.req_ready, m0_if.req_ready}, 2'b00);
      chk("rst re/we", {ram_re0, ram_we0}, 2'b00);
      chk("rst init_done", init_done, 1'b0);
      chk("rst resp", {m1_if.resp_valid, m0_if.resp_valid}, 2'b00);
      @(posedge clk);
      #1;
      rst = 1'b0;
      m0_if.req_valid = 1'b0;
      m1_if.req_valid = 1'b0;
      wait_init();

`ifdef RAM_ARB_ZERO_INIT_EN
      step(1, 0, 12'h009, '0, 0, 0, '0, '0, 2'b01, 8'h00);
      idle();
`endif
      // single requester write then read
      step(1, 1, 12'h123, 8'hA5, 0, 0, '0, '0, 2'b01, '0);
      step(1, 0, 12'h123, '0, 0, 0, '0, '0, 2'b01, 8'hA5);
      idle();
      step(1, 1, 12'h010, 8'h11, 0, 0, '0, '0, 2'b01, '0);
      step(0, 0, '0, '0, 1, 1, 12'h020, 8'h22, 2'b10, '0);
      // contention: both reading for four cycles
      for (int i = 0; i < 2; i++) begin
         step(1, 0, 12'h010, '0, 1, 0, 12'h020, '0, 2'b01, 8'h11);
         step(1, 0, 12'h010, '0, 1, 0, 12'h020, '0, 2'b10, 8'h22);
      end
      idle();
      // fairness after m1 alone
      step(0, 0, '0, '0, 1, 0, 12'h020, '0, 2'b10, 8'h22);
      step(1, 0, 12'h010, '0, 1, 0, 12'h020, '0, 2'b01, 8'h11);
      step(1, 0, 12'h010, '0, 1, 0, 12'h020, '0, 2'b10, 8'h22);
      // read-after-write across requesters
      step(0, 0, '0, '0, 1, 1, 12'h7FF, 8'h3C, 2'b10, '0);
      step(1, 0, 12'h7FF, '0, 0, 0, '0, '0, 2'b01, 8'h3C);
      idle();
      idle();
      // reset while a read is in flight
      step(1, 0, 12'h123, '0, 0, 0, '0, '0, 2'b01, '0, 1'b0);
      rst = 1'b1;
      m0_if.req_valid = 1'b0;
      @(negedge clk);
      chk("rst mid resp T+1", m0_if.resp_valid, 1'b0);
      chk("rst mid init_done", init_done, 1'b0);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst mid resp T+2", m0_if.resp_valid, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      wait_init();
      step(1, 0, 12'h7FF, '0, 0, 0, '0, '0, 2'b01,
`ifdef RAM_ARB_ZERO_INIT_EN
           8'h00);
`else
           8'h3C);
`endif
      idle();
      idle();
      chk("q0 drained", q0.size(), 0);
      chk("q1 drained", q1.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_fail);
      $finish;
   end
endmodule
